// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece control path:
// shape bitmaps, the random-index table, spawn defaults and FSM/action encodings.
package tetris_pkg;

    localparam int SPAWN_X_DEF = 6;
    localparam int SPAWN_Y_DEF = 23;
    localparam int NUM_ACT     = 6;

    localparam logic [15:0] SHAPE_I = 16'h4444;
    localparam logic [15:0] SHAPE_L = 16'h4460;
    localparam logic [15:0] SHAPE_J = 16'h2260;
    localparam logic [15:0] SHAPE_Z = 16'h0C60;
    localparam logic [15:0] SHAPE_S = 16'h06C0;
    localparam logic [15:0] SHAPE_T = 16'h0E40;
    localparam logic [15:0] SHAPE_O = 16'h0660;

    typedef enum logic [2:0] {
        ST_OVER  = 3'd0,
        ST_SPAWN = 3'd1,
        ST_SRES  = 3'd2,
        ST_IDLE  = 3'd3,
        ST_RES   = 3'd4,
        ST_LOCK  = 3'd5,
        ST_CLEAR = 3'd6
    } state_e;

    // Encoding doubles as the pending-bit index; lower index wins arbitration.
    typedef enum logic [2:0] {
        ACT_CW    = 3'd0,
        ACT_CCW   = 3'd1,
        ACT_LEFT  = 3'd2,
        ACT_RIGHT = 3'd3,
        ACT_DROP  = 3'd4,
        ACT_TICK  = 3'd5
    } action_e;

    function automatic logic [15:0] rand_shape(input logic [2:0] r);
        logic [15:0] s;
        case (r)
            3'd0:    s = SHAPE_I;
            3'd1:    s = SHAPE_L;
            3'd2:    s = SHAPE_J;
            3'd3:    s = SHAPE_Z;
            3'd4:    s = SHAPE_S;
            3'd5:    s = SHAPE_T;
            default: s = SHAPE_O;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/piece_sequencer_if.sv
// Request/response link between the piece sequencer and the shared collision checker.
interface piece_sequencer_if;
    logic        chk_req;
    logic [3:0]  chk_x;
    logic [4:0]  chk_y;
    logic [15:0] chk_shape;
    logic        chk_ok;

    modport master (output chk_req, chk_x, chk_y, chk_shape, input chk_ok);
    modport slave  (input chk_req, chk_x, chk_y, chk_shape, output chk_ok);
endinterface

// File: rtl/piece_sequencer_arbiter.sv
// Latches action pulses and grants the lowest-index pending action;
// the granted bit drops on issue unless the same action pulses again.
module action_arbiter
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_ACT-1:0] req_pulse,
    input  logic               accept,
    input  logic               flush,
    input  logic               issue,
    output logic [NUM_ACT-1:0] grant,
    output logic               any
);

    logic [NUM_ACT-1:0] pend_q;
    logic [NUM_ACT-1:0] pend_d;

    // Fixed-priority grant and next pending state.
    always_comb begin
        grant  = pend_q & (~pend_q + 6'd1);
        any    = (pend_q != 6'd0);
        pend_d = flush ? 6'd0
                       : ((pend_q & ~(issue ? grant : 6'd0)) | (accept ? req_pulse : 6'd0));
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 6'd0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// Single-piece control FSM: arbitrates action pulses onto one shared collision
// checker and sequences spawn, move, lock, line-clear handoff and game-over.
module piece_sequencer
    import tetris_pkg::*;
#(
    parameter int SPAWN_X = SPAWN_X_DEF,
    parameter int SPAWN_Y = SPAWN_Y_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               rot_cw,
    input  logic               rot_ccw,
    input  logic               left,
    input  logic               right,
    input  logic               drop,
    input  logic               tick,
    input  logic [2:0]         rand_idx,
    input  logic [15:0]        rot_shape,
    output logic               rot_dir,
    piece_sequencer_if.master  chk,
    output logic [3:0]         pos_x,
    output logic [4:0]         pos_y,
    output logic [15:0]        shape,
    output logic               lock,
    input  logic               clr_done,
    input  logic [2:0]         rows,
    output logic               board_clr,
    output logic               score_hit,
    output logic [1:0]         line_cnt,
    output logic               game_over
);

    localparam logic [3:0] SPX = 4'(SPAWN_X);
    localparam logic [4:0] SPY = 5'(SPAWN_Y);

    state_e      state_q, state_d;
    action_e     act_q, act_d, act_s;
    logic [3:0]  pos_x_q, pos_x_d, cand_x_q, cand_x_d, nx_x_s;
    logic [4:0]  pos_y_q, pos_y_d, cand_y_q, cand_y_d, nx_y_s;
    logic [15:0] shape_q, shape_d, cand_shape_q, cand_shape_d, nx_shape_s;
    logic        lock_q, lock_d, board_clr_q, board_clr_d;
    logic        score_hit_q, score_hit_d, game_over_q, game_over_d;
    logic [1:0]  line_cnt_q, line_cnt_d;
    logic        chk_req_s, issue_s, flush_s, accept_s, any_s, down_s;
    logic [3:0]  chk_x_s;
    logic [4:0]  chk_y_s;
    logic [15:0] chk_shape_s;
    logic [NUM_ACT-1:0] grant_s;

    assign accept_s = !start && ((state_q == ST_SRES) || (state_q == ST_IDLE) || (state_q == ST_RES));

    action_arbiter u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse ({tick, drop, right, left, rot_ccw, rot_cw}),
        .accept    (accept_s),
        .flush     (flush_s),
        .issue     (issue_s),
        .grant     (grant_s),
        .any       (any_s)
    );

    // Decode the granted action and build its candidate placement.
    always_comb begin
        case (grant_s)
            6'b000001: act_s = ACT_CW;
            6'b000010: act_s = ACT_CCW;
            6'b000100: act_s = ACT_LEFT;
            6'b001000: act_s = ACT_RIGHT;
            6'b010000: act_s = ACT_DROP;
            6'b100000: act_s = ACT_TICK;
            default:   act_s = ACT_CW;
        endcase
        rot_dir    = (act_s == ACT_CCW);
        down_s     = (act_s == ACT_DROP) || (act_s == ACT_TICK);
        nx_x_s     = pos_x_q;
        nx_y_s     = pos_y_q;
        nx_shape_s = shape_q;
        case (act_s)
            ACT_CW, ACT_CCW: nx_shape_s = rot_shape;
            ACT_LEFT:        nx_x_s     = pos_x_q - 4'd1;
            ACT_RIGHT:       nx_x_s     = pos_x_q + 4'd1;
            default:         nx_y_s     = pos_y_q - 5'd1;
        endcase
    end

    // FSM next state, check requests and strobe generation.
    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        shape_d      = shape_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        cand_shape_d = cand_shape_q;
        board_clr_d  = 1'b0;
        score_hit_d  = 1'b0;
        line_cnt_d   = line_cnt_q;
        chk_req_s    = 1'b0;
        chk_x_s      = pos_x_q;
        chk_y_s      = pos_y_q;
        chk_shape_s  = shape_q;
        issue_s      = 1'b0;
        flush_s      = 1'b0;
        if (start) begin
            board_clr_d = 1'b1;
            flush_s     = 1'b1;
            state_d     = ST_SPAWN;
        end else begin
            case (state_q)
                ST_SPAWN: begin
                    shape_d     = rand_shape(rand_idx);
                    pos_x_d     = SPX;
                    pos_y_d     = SPY;
                    chk_req_s   = 1'b1;
                    chk_x_s     = SPX;
                    chk_y_s     = SPY;
                    chk_shape_s = rand_shape(rand_idx);
                    state_d     = ST_SRES;
                end
                ST_SRES: state_d = chk_ok_ok() ? ST_IDLE : ST_OVER;
                ST_IDLE: begin
                    if (any_s) begin
                        issue_s = 1'b1;
                        act_d   = act_s;
                        // Moving down from row 0 fails without spending a check.
                        if (down_s && (pos_y_q == 5'd0)) begin
                            state_d = ST_LOCK;
                        end else begin
                            chk_req_s    = 1'b1;
                            chk_x_s      = nx_x_s;
                            chk_y_s      = nx_y_s;
                            chk_shape_s  = nx_shape_s;
                            cand_x_d     = nx_x_s;
                            cand_y_d     = nx_y_s;
                            cand_shape_d = nx_shape_s;
                            state_d      = ST_RES;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RES: begin
                    if (chk_ok_ok()) begin
                        pos_x_d = cand_x_q;
                        pos_y_d = cand_y_q;
                        shape_d = cand_shape_q;
                        if (act_q != ACT_DROP) begin
                            state_d = ST_IDLE;
                        end else if (cand_y_q == 5'd0) begin
                            state_d = ST_LOCK;
                        end else begin
                            chk_req_s   = 1'b1;
                            chk_x_s     = cand_x_q;
                            chk_y_s     = cand_y_q - 5'd1;
                            chk_shape_s = cand_shape_q;
                            cand_y_d    = cand_y_q - 5'd1;
                        end
                    end else begin
                        state_d = ((act_q == ACT_DROP) || (act_q == ACT_TICK)) ? ST_LOCK : ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    flush_s = 1'b1;
                    state_d = ST_CLEAR;
                end
                ST_CLEAR: begin
                    if (clr_done) begin
                        if (rows != 3'd0) begin
                            score_hit_d = 1'b1;
                            line_cnt_d  = 2'(rows - 3'd1);
                        end else begin
                            score_hit_d = 1'b0;
                        end
                        state_d = ST_SPAWN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                default: state_d = ST_OVER;
            endcase
        end
        lock_d      = (state_d == ST_LOCK);
        game_over_d = (state_d == ST_OVER);
    end

    function automatic logic chk_ok_ok();
        return chk.chk_ok;
    endfunction

    // State, piece and registered-strobe flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OVER;
            act_q        <= ACT_CW;
            pos_x_q      <= SPX;
            pos_y_q      <= SPY;
            shape_q      <= 16'h0000;
            cand_x_q     <= 4'd0;
            cand_y_q     <= 5'd0;
            cand_shape_q <= 16'h0000;
            lock_q       <= 1'b0;
            board_clr_q  <= 1'b0;
            score_hit_q  <= 1'b0;
            line_cnt_q   <= 2'd0;
            game_over_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            act_q        <= act_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            shape_q      <= shape_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            cand_shape_q <= cand_shape_d;
            lock_q       <= lock_d;
            board_clr_q  <= board_clr_d;
            score_hit_q  <= score_hit_d;
            line_cnt_q   <= line_cnt_d;
            game_over_q  <= game_over_d;
        end
    end

    assign chk.chk_req   = chk_req_s;
    assign chk.chk_x     = chk_x_s;
    assign chk.chk_y     = chk_y_s;
    assign chk.chk_shape = chk_shape_s;
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign shape         = shape_q;
    assign lock          = lock_q;
    assign board_clr     = board_clr_q;
    assign score_hit     = score_hit_q;
    assign line_cnt      = line_cnt_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench: mock checker rejecting rows below a floor, a scoreboard of
// expected check requests, and directed scenarios for spawn, moves, drop, clear and restart.
module tb_piece_sequencer;
    import tetris_pkg::*;

    logic        clk, rst_n, start, rot_cw, rot_ccw, left, right, drop, tick_i;
    logic [2:0]  rand_idx, rows;
    logic [15:0] rot_shape, shape;
    logic        rot_dir, lock, clr_done, board_clr, score_hit, game_over;
    logic [3:0]  pos_x;
    logic [4:0]  pos_y;
    logic [1:0]  line_cnt;

    piece_sequencer_if cif ();

    piece_sequencer dut (
        .clk (clk), .rst_n (rst_n), .start (start),
        .rot_cw (rot_cw), .rot_ccw (rot_ccw), .left (left), .right (right),
        .drop (drop), .tick (tick_i), .rand_idx (rand_idx),
        .rot_shape (rot_shape), .rot_dir (rot_dir), .chk (cif.master),
        .pos_x (pos_x), .pos_y (pos_y), .shape (shape), .lock (lock),
        .clr_done (clr_done), .rows (rows), .board_clr (board_clr),
        .score_hit (score_hit), .line_cnt (line_cnt), .game_over (game_over)
    );

    int n_checks = 0;
    int n_errors = 0;
    int floor_lim = 0;
    int cyc;
    logic [24:0] sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for Rotate: cw rotates bits left, ccw rotates them right.
    function automatic logic [15:0] rot_model(input logic [15:0] s, input logic d);
        return d ? {s[0], s[15:1]} : {s[14:0], s[15]};
    endfunction
    assign rot_shape = rot_model(shape, rot_dir);

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] x, input logic [4:0] y, input logic [15:0] s);
        sb_q.push_back({x, y, s});
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Mock collision checker: one-cycle latency, rejects rows below floor_lim.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cif.chk_ok <= 1'b0;
        else        cif.chk_ok <= cif.chk_req && (int'(cif.chk_y) >= floor_lim);
    end

    // Every request must match the next expected candidate.
    always @(negedge clk) begin
        if (rst_n && cif.chk_req) begin
            check_eq("req_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0)
                check_eq("chk_cand", 32'({cif.chk_x, cif.chk_y, cif.chk_shape}), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        {start, rot_cw, rot_ccw, left, right, drop, tick_i, clr_done} = 8'd0;
        rand_idx = 3'd0;
        rows     = 3'd0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_game_over", 32'(game_over), 32'd1);
        check_eq("rst_pos", 32'({pos_x, pos_y}), 32'({4'd6, 5'd23}));
        check_eq("rst_shape", 32'(shape), 32'd0);
        check_eq("rst_strobes", 32'({cif.chk_req, lock, board_clr, score_hit, line_cnt}), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Start with I piece.
        push_exp(4'd6, 5'd23, SHAPE_I);
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("start_board_clr", 32'(board_clr), 32'd1);
        cycle();
        check_eq("board_clr_width", 32'(board_clr), 32'd0);
        cycle();
        check_eq("spawn_game_over", 32'(game_over), 32'd0);
        check_eq("spawn_piece", 32'({pos_x, pos_y, shape}), 32'({4'd6, 5'd23, SHAPE_I}));

        // left and right together: left first, right two cycles later.
        push_exp(4'd5, 5'd23, SHAPE_I);
        push_exp(4'd6, 5'd23, SHAPE_I);
        left = 1'b1; right = 1'b1; cycle(); left = 1'b0; right = 1'b0;
        cycle(); cycle();
        check_eq("left_pos_x", 32'(pos_x), 32'd5);
        cycle(); cycle();
        check_eq("right_pos_x", 32'(pos_x), 32'd6);

        // Rotations.
        push_exp(4'd6, 5'd23, 16'h8888);
        rot_cw = 1'b1; cycle(); rot_cw = 1'b0; cycle(); cycle();
        check_eq("rot_cw_shape", 32'(shape), 32'h8888);
        push_exp(4'd6, 5'd23, SHAPE_I);
        rot_ccw = 1'b1; cycle(); rot_ccw = 1'b0; cycle(); cycle();
        check_eq("rot_ccw_shape", 32'(shape), 32'(SHAPE_I));

        // Hard drop onto a floor at row 20.
        floor_lim = 20;
        for (int y = 22; y >= 19; y--) push_exp(4'd6, 5'(y), SHAPE_I);
        drop = 1'b1; cycle(); drop = 1'b0;
        cyc = 1;
        while (!lock && cyc < 30) begin cycle(); cyc++; end
        check_eq("drop_lock", 32'(lock), 32'd1);
        check_eq("drop_lock_cycle", 32'(cyc), 32'd6);
        check_eq("drop_pos_y", 32'(pos_y), 32'd20);
        cycle();
        check_eq("lock_width", 32'(lock), 32'd0);

        // Line clear of three rows.
        rand_idx = 3'd5;
        push_exp(4'd6, 5'd23, SHAPE_T);
        clr_done = 1'b1; rows = 3'd3; cycle(); clr_done = 1'b0; rows = 3'd0;
        check_eq("score_hit", 32'(score_hit), 32'd1);
        check_eq("line_cnt", 32'(line_cnt), 32'd2);
        cycle();
        check_eq("score_hit_width", 32'(score_hit), 32'd0);
        cycle();
        check_eq("respawn_piece", 32'({pos_y, shape}), 32'({5'd23, SHAPE_T}));

        // Spawn collision ends the game; later pulses are ignored.
        floor_lim = 24;
        rand_idx = 3'd2;
        push_exp(4'd6, 5'd23, SHAPE_J);
        start = 1'b1; cycle(); start = 1'b0; cycle(); cycle();
        check_eq("over_game_over", 32'(game_over), 32'd1);
        rot_cw = 1'b1; tick_i = 1'b1; cycle(); rot_cw = 1'b0; tick_i = 1'b0;
        repeat (6) cycle();
        check_eq("over_still", 32'(game_over), 32'd1);

        // Restart; rand 6 maps to O.
        floor_lim = 0;
        rand_idx = 3'd6;
        push_exp(4'd6, 5'd23, SHAPE_O);
        start = 1'b1; cycle(); start = 1'b0; cycle(); cycle();
        check_eq("restart_piece", 32'({game_over, shape}), 32'({1'b0, SHAPE_O}));

        // start mid-drop aborts the drop and flushes a pending tick.
        push_exp(4'd6, 5'd22, SHAPE_O);
        drop = 1'b1; cycle(); drop = 1'b0;
        tick_i = 1'b1; cycle(); tick_i = 1'b0;
        rand_idx = 3'd7;
        push_exp(4'd6, 5'd23, SHAPE_O);
        start = 1'b1; cycle(); start = 1'b0;
        check_eq("abort_board_clr", 32'(board_clr), 32'd1);
        check_eq("abort_pos_y", 32'(pos_y), 32'd23);
        cycle(); cycle();
        check_eq("abort_respawn", 32'(game_over), 32'd0);
        repeat (4) cycle();
        check_eq("abort_pos_held", 32'(pos_y), 32'd23);

        // Drop all the way to row 0: no check below the floor row.
        for (int y = 22; y >= 0; y--) push_exp(4'd6, 5'(y), SHAPE_O);
        drop = 1'b1; cycle(); drop = 1'b0;
        cyc = 1;
        while (!lock && cyc < 60) begin cycle(); cyc++; end
        check_eq("floor_lock", 32'(lock), 32'd1);
        check_eq("floor_pos_y", 32'(pos_y), 32'd0);
        check_eq("floor_sb_empty", 32'(sb_q.size()), 32'd0);
        cycle();
        rand_idx = 3'd3;
        push_exp(4'd6, 5'd23, SHAPE_Z);
        clr_done = 1'b1; rows = 3'd0; cycle(); clr_done = 1'b0;
        check_eq("zero_rows_no_hit", 32'({score_hit, line_cnt}), 32'({1'b0, 2'd2}));
        cycle(); cycle();
        check_eq("final_piece", 32'({pos_y, shape}), 32'({5'd23, SHAPE_Z}));
        repeat (3) cycle();
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
